multicycle_control_fsm: RTL

//   Control FSM for the multicycle RV32I core: sequences the shared ULA, the unified

---
 rtl/multicycle_control_fsm.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RV32I core: sequences ULA, unified memory, IR, PC and
// register file through 3-5 states per instruction, one state per enabled clock.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ULAControl,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [3:0] state_dbg,
  output logic       illegal
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ULA    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  state_t state;
  state_t state_next;
  logic   illegal_set;
  logic   pc_update;
  logic   branch;
  logic   alu_funct;
  logic   sub_allowed;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else if (en) begin
      state <= state_next;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = S_FETCH;
    illegal_set = 1'b0;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BEQ;
          default: begin
            state_next  = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore decode per state, plus zero-gated branch write and reset/enable masking
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_funct   = 1'b0;
    sub_allowed = 1'b0;
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    ULAControl  = ULA_ADD;
    ImmSrc      = IMM_I;
    state_dbg   = 4'(state);

    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase

    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ULA;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA     = SRCA_RD1;
        alu_funct   = 1'b1;
        sub_allowed = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        alu_funct = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RD1;
        ULAControl = ULA_SUB;
        branch     = 1'b1;
      end
      default: ;
    endcase

    // addi never subtracts: only the register form honours funct7_5
    if (alu_funct) begin
      case (funct3)
        3'b000:  ULAControl = (sub_allowed & op[5] & funct7_5) ? ULA_SUB : ULA_ADD;
        3'b010:  ULAControl = ULA_SLT;
        3'b110:  ULAControl = ULA_OR;
        3'b111:  ULAControl = ULA_AND;
        default: ULAControl = ULA_ADD;
      endcase
    end

    PCWrite = pc_update | (branch & zero);

    if (!en) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end

    if (rst) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ULA;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_FOUR;
      ULAControl = ULA_ADD;
      state_dbg  = '0;
    end
  end

endmodule
